// File: rtl/obq_resolve_ctrl.sv
// rtl/obq_resolve_ctrl.sv - branch tracker turning resolves into OBQ clears and retires into OBQ shifts
module obq_resolve_ctrl #(
  parameter int OBQ_SIZE = 16,
  parameter int TAG_W    = $clog2(OBQ_SIZE)
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             alloc_en,
  input  logic [TAG_W-1:0] alloc_tag,
  input  logic             resolve_en,
  input  logic [TAG_W-1:0] resolve_tag,
  input  logic             resolve_mispred,
  input  logic             retire_en,
  output logic             clear_en,
  output logic [TAG_W:0]   index,
  output logic             shift_en,
  output logic [TAG_W:0]   shift_index,
  output logic             retire_ready,
  output logic [TAG_W:0]   count_out,
  output logic             err_out
);

  // Tracker storage: one {tag, resolved} pair per slot, valid from head for count entries.
  logic [TAG_W-1:0] tag_q [OBQ_SIZE];
  logic [OBQ_SIZE-1:0] res_q;
  logic [TAG_W-1:0] head_q;
  logic [TAG_W-1:0] tail_q;
  logic [TAG_W:0]   count_q;

  logic             clear_q;
  logic [TAG_W:0]   index_q;
  logic             shift_q;
  logic [TAG_W:0]   shift_index_q;
  logic             err_q;

  logic             hit;
  logic [TAG_W-1:0] hit_off;
  logic [TAG_W-1:0] hit_pos;
  logic             resolve_hit;
  logic             mispred;
  logic             retire_ok;
  logic             alloc_room;
  logic             alloc_ok;
  logic             err_next;
  logic [TAG_W:0]   count_next;

  // Oldest-first search of the valid window for the resolving tag.
  always_comb begin
    hit     = 1'b0;
    hit_off = '0;
    for (int i = 0; i < OBQ_SIZE; i++) begin
      if (!hit && ((TAG_W+1)'(i) < count_q) &&
          (tag_q[head_q + TAG_W'(i)] == resolve_tag)) begin
        hit     = 1'b1;
        hit_off = TAG_W'(i);
      end
    end
  end

  assign hit_pos      = head_q + hit_off;
  assign retire_ready = (count_q != '0) && res_q[head_q];
  assign count_out    = count_q;

  // Event qualification; a mispredict redirects fetch so a same-cycle alloc is silently dropped.
  always_comb begin
    resolve_hit = resolve_en && hit;
    mispred     = resolve_hit && resolve_mispred;
    retire_ok   = retire_en && retire_ready;
    alloc_room  = (count_q < (TAG_W+1)'(OBQ_SIZE)) || retire_ok;
    alloc_ok    = alloc_en && !mispred && alloc_room;
    err_next    = (alloc_en && !mispred && !alloc_room) ||
                  (resolve_en && !hit) ||
                  (retire_en && !retire_ready);
    if (mispred) begin
      count_next = {1'b0, hit_off} + (TAG_W+1)'(1) - (TAG_W+1)'(retire_ok);
    end else begin
      count_next = count_q + (TAG_W+1)'(alloc_ok) - (TAG_W+1)'(retire_ok);
    end
  end

  // Tracker state update; alloc writes after the resolve mark so a recycled slot starts unresolved.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < OBQ_SIZE; i++) begin
        tag_q[i] <= '0;
      end
      res_q   <= '0;
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      if (resolve_hit) begin
        res_q[hit_pos] <= 1'b1;
      end
      if (alloc_ok) begin
        tag_q[tail_q] <= alloc_tag;
        res_q[tail_q] <= 1'b0;
        tail_q        <= tail_q + TAG_W'(1);
      end
      if (mispred) begin
        tail_q <= hit_pos + TAG_W'(1);
      end
      if (retire_ok) begin
        head_q <= head_q + TAG_W'(1);
      end
      count_q <= count_next;
    end
  end

  // Registered single-cycle OBQ command and error pulses; indices hold between pulses.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      clear_q       <= 1'b0;
      index_q       <= '0;
      shift_q       <= 1'b0;
      shift_index_q <= '0;
      err_q         <= 1'b0;
    end else begin
      clear_q <= mispred;
      shift_q <= retire_ok;
      err_q   <= err_next;
      if (mispred) begin
        index_q <= {1'b0, resolve_tag + TAG_W'(1)};
      end
      if (retire_ok) begin
        shift_index_q <= {1'b0, tag_q[head_q] + TAG_W'(1)};
      end
    end
  end

  assign clear_en    = clear_q;
  assign index       = index_q;
  assign shift_en    = shift_q;
  assign shift_index = shift_index_q;
  assign err_out     = err_q;

endmodule

// File: tb/tb_obq_resolve_ctrl.sv
// tb/tb_obq_resolve_ctrl.sv - scoreboard bench for obq_resolve_ctrl against a queue-based model
`timescale 1ns/1ps
module tb_obq_resolve_ctrl;
  localparam int N     = 16;
  localparam int TAG_W = 4;

  logic             clock = 1'b0;
  logic             reset = 1'b0;
  logic             alloc_en = 1'b0;
  logic [TAG_W-1:0] alloc_tag = '0;
  logic             resolve_en = 1'b0;
  logic [TAG_W-1:0] resolve_tag = '0;
  logic             resolve_mispred = 1'b0;
  logic             retire_en = 1'b0;
  logic             clear_en;
  logic [TAG_W:0]   index;
  logic             shift_en;
  logic [TAG_W:0]   shift_index;
  logic             retire_ready;
  logic [TAG_W:0]   count_out;
  logic             err_out;

  obq_resolve_ctrl #(.OBQ_SIZE(N)) dut (
    .clock(clock), .reset(reset),
    .alloc_en(alloc_en), .alloc_tag(alloc_tag),
    .resolve_en(resolve_en), .resolve_tag(resolve_tag), .resolve_mispred(resolve_mispred),
    .retire_en(retire_en),
    .clear_en(clear_en), .index(index),
    .shift_en(shift_en), .shift_index(shift_index),
    .retire_ready(retire_ready), .count_out(count_out), .err_out(err_out)
  );

  always #5 clock = ~clock;

  typedef struct {
    bit clr; int idx; bit sh; int shidx; bit err; int cnt; bit rdy;
  } exp_t;

  exp_t exp_q[$];
  int   m_tag[$];
  bit   m_res[$];
  int   n_tests = 0;
  int   n_fail  = 0;
  bit   last_acc;
  bit   last_mis;
  int   next_tag;

  task automatic check(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Drive one cycle of inputs and push the model's expected response for the following cycle.
  task automatic step(input bit a_en, input int a_tag, input bit r_en, input int r_tag,
                      input bit r_mis, input bit t_en);
    exp_t e;
    int   idx;
    int   sz;
    bit   hit, mis, ready, ret_ok, room;
    @(negedge clock);
    alloc_en = a_en; alloc_tag = a_tag[TAG_W-1:0];
    resolve_en = r_en; resolve_tag = r_tag[TAG_W-1:0]; resolve_mispred = r_mis;
    retire_en = t_en;
    sz    = m_tag.size();
    ready = (sz > 0) && m_res[0];
    idx   = -1;
    for (int i = 0; i < sz; i++) if (idx < 0 && m_tag[i] == r_tag) idx = i;
    hit    = r_en && (idx >= 0);
    mis    = hit && r_mis;
    ret_ok = t_en && ready;
    room   = (sz < N) || ret_ok;
    e.err  = (r_en && idx < 0) || (t_en && !ready) || (a_en && !mis && !room);
    e.clr  = mis;
    e.idx  = (r_tag + 1) % N;
    e.sh   = ret_ok;
    e.shidx = ret_ok ? (m_tag[0] + 1) % N : 0;
    if (hit) m_res[idx] = 1'b1;
    if (mis) while (m_tag.size() > idx + 1) begin void'(m_tag.pop_back()); void'(m_res.pop_back()); end
    if (ret_ok) begin void'(m_tag.pop_front()); void'(m_res.pop_front()); end
    last_acc = a_en && !mis && room;
    last_mis = mis;
    if (last_acc) begin m_tag.push_back(a_tag); m_res.push_back(1'b0); end
    e.cnt = m_tag.size();
    e.rdy = (m_tag.size() > 0) && m_res[0];
    exp_q.push_back(e);
  endtask

  task automatic idle();
    step(0, 0, 0, 0, 0, 0);
  endtask

  // Wait for the scoreboard to drain, then assert reset (possibly mid-pulse) and check outputs drop.
  task automatic do_reset();
    for (int k = 0; k < 10 && exp_q.size() > 0; k++) @(posedge clock);
    #3;
    if (exp_q.size() > 0) begin
      check("scoreboard_drain", exp_q.size(), 0);
      exp_q.delete();
    end
    reset = 1'b0;
    alloc_en = 0; resolve_en = 0; resolve_mispred = 0; retire_en = 0;
    m_tag.delete(); m_res.delete();
    #1;
    check("rst_clear_en", int'(clear_en), 0);
    check("rst_shift_en", int'(shift_en), 0);
    check("rst_err_out", int'(err_out), 0);
    check("rst_index", int'(index), 0);
    check("rst_shift_index", int'(shift_index), 0);
    check("rst_count_out", int'(count_out), 0);
    check("rst_retire_ready", int'(retire_ready), 0);
    repeat (2) @(posedge clock);
    @(negedge clock);
    reset = 1'b1;
  endtask

  // Monitor: one expected record per driven cycle, compared just after the capturing edge.
  initial begin
    exp_t e;
    forever begin
      @(posedge clock);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check("clear_en", int'(clear_en), int'(e.clr));
        if (e.clr) check("index", int'(index), e.idx);
        check("shift_en", int'(shift_en), int'(e.sh));
        if (e.sh) check("shift_index", int'(shift_index), e.shidx);
        check("err_out", int'(err_out), int'(e.err));
        check("count_out", int'(count_out), e.cnt);
        check("retire_ready", int'(retire_ready), int'(e.rdy));
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int a_tag, r_tag;
    do_reset();

    // Mispredict of tag 1 among 0..3 truncates to 2 entries.
    for (int t = 0; t < 4; t++) step(1, t, 0, 0, 0, 0);
    step(0, 0, 1, 1, 1, 0);
    step(0, 0, 1, 2, 0, 0);
    idle();

    // Correct resolve then retire of tag 0.
    do_reset();
    for (int t = 0; t < 3; t++) step(1, t, 0, 0, 0, 0);
    step(0, 0, 1, 0, 0, 0);
    step(0, 0, 0, 0, 0, 1);
    idle();

    // Illegal retire and untracked resolve.
    step(0, 0, 0, 0, 0, 1);
    step(0, 0, 1, 9, 1, 0);
    idle();

    // Fill with tags 12..15,0..11, overflow, then retire through tag 15.
    do_reset();
    for (int t = 0; t < N; t++) step(1, (12 + t) % N, 0, 0, 0, 0);
    step(1, 12, 0, 0, 0, 0);
    for (int t = 12; t < 16; t++) begin
      step(0, 0, 1, t, 0, 0);
      step(0, 0, 0, 0, 0, 1);
    end
    step(1, 12, 0, 0, 0, 1);
    idle();

    // Full tracker: alloc plus successful retire in one cycle is accepted.
    do_reset();
    for (int t = 0; t < N; t++) step(1, t, 0, 0, 0, 0);
    step(0, 0, 1, 0, 0, 0);
    step(1, 0, 0, 0, 0, 1);
    idle();

    // Mispredict of tag 15 wraps the clear index to 0; reset then lands mid-pulse.
    do_reset();
    step(1, 15, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0, 0);
    step(1, 1, 0, 0, 0, 0);
    step(0, 0, 1, 15, 1, 0);
    do_reset();

    // Mispredict with same-cycle alloc, then retire and mispredict of the same head.
    step(1, 3, 0, 0, 0, 0);
    step(1, 4, 0, 0, 0, 0);
    step(1, 5, 1, 4, 1, 0);
    step(0, 0, 1, 3, 0, 0);
    step(0, 0, 1, 3, 1, 1);
    idle();

    // Retire of head plus mispredict of a younger entry.
    for (int t = 6; t < 10; t++) step(1, t, 0, 0, 0, 0);
    step(0, 0, 1, 6, 0, 0);
    step(0, 0, 1, 8, 1, 1);
    idle();

    // Randomized traffic.
    do_reset();
    next_tag = 0;
    for (int c = 0; c < 3000; c++) begin
      bit a, r, m, t;
      a = ($urandom_range(0, 99) < 45);
      a_tag = ($urandom_range(0, 9) == 0) ? int'($urandom_range(0, N - 1)) : next_tag;
      r = ($urandom_range(0, 99) < 40);
      if (m_tag.size() > 0 && $urandom_range(0, 99) < 85)
        r_tag = m_tag[$urandom_range(0, m_tag.size() - 1)];
      else
        r_tag = $urandom_range(0, N - 1);
      m = ($urandom_range(0, 99) < 20);
      t = ($urandom_range(0, 99) < 40);
      step(a, a_tag, r, r_tag, m, t);
      if (last_acc) next_tag = (a_tag + 1) % N;
      if (last_mis) next_tag = (r_tag + 1) % N;
    end
    idle();

    for (int k = 0; k < 10 && exp_q.size() > 0; k++) @(posedge clock);
    #3;
    if (exp_q.size() > 0) check("final_drain", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/obq_resolve_ctrl.md
Name: obq_resolve_ctrl

Overview:
Branch-resolution side of the OBQ. Tracks every in-flight branch by the OBQ row tag it received at allocation, in program order. Converts branch outcomes into OBQ clear commands (mispredict squash plus history-bit flip) and in-order retirement into OBQ shift commands (head advance). Sits between the execute/ROB stage and the OBQ write-side ports clear_en/index and shift_en/shift_index.

Parameters:
OBQ_SIZE, 16, number of OBQ rows and tracker entries; must be a power of 2.
TAG_W, $clog2(OBQ_SIZE), width of an OBQ row tag.

Ports:
clock  in  1  system clock; all state updates on posedge.
reset  in  1  asynchronous, active-low; asserting it clears all state immediately.
alloc_en  in  1  a branch was written into the OBQ this cycle.
alloc_tag  in  TAG_W  OBQ row_tag of that branch.
resolve_en  in  1  a branch resolved this cycle.
resolve_tag  in  TAG_W  tag of the resolving branch.
resolve_mispred  in  1  the resolving branch was mispredicted.
retire_en  in  1  the ROB retires the oldest tracked branch.
clear_en  out  1  OBQ clear command.
index  out  TAG_W+1  OBQ clear index.
shift_en  out  1  OBQ shift command.
shift_index  out  TAG_W+1  new OBQ head.
retire_ready  out  1  oldest tracked branch is resolved.
count_out  out  TAG_W+1  number of tracked branches.
err_out  out  1  one-cycle pulse on an illegal request.

Behaviour:
- State: circular tracker of OBQ_SIZE entries {tag, resolved}, head/tail pointers (TAG_W bits each) and count (TAG_W+1 bits).
- Reset (reset==0, asynchronous): head=tail=count=0, all resolved bits=0. Outputs: clear_en=0, shift_en=0, err_out=0, index=0, shift_index=0. Combinational outputs follow state: retire_ready=0, count_out=0.
- Allocation: if alloc_en and count<OBQ_SIZE, write {alloc_tag, 0} at tail; tail+1 (mod OBQ_SIZE); count+1.
- Allocation when full: dropped; err_out=1 next cycle.
- Resolve lookup: compare resolve_tag against all valid entries (head..tail-1, wrap-aware).
  - Hit: set that entry's resolved bit.
  - Miss: ignored; err_out=1 next cycle.
- Correct prediction (resolve hit, mispred=0): no OBQ command is issued.
- Mispredict (resolve hit, mispred=1), at position p:
  - Tracker tail = p+1 and count recomputed; all younger entries are discarded.
  - Next cycle: clear_en=1 and index={1'b0, resolve_tag+1 mod OBQ_SIZE}. The OBQ truncates to this index and flips the last history bit of the row at index-1.
- Alloc in the same cycle as a mispredict: the alloc is suppressed, because fetch is being redirected. No error is raised.
- retire_ready = (count>0) & resolved[head].
- Retire:
  - If retire_en and retire_ready: head+1 and count-1. Next cycle: shift_en=1 and shift_index={1'b0, tag[head]+1 mod OBQ_SIZE}.
  - retire_en while !retire_ready: ignored; err_out=1 next cycle.
- Same-cycle events:
  - Retire and mispredict of the same entry: both apply. Tracker becomes empty; clear and shift are both issued with the same index value.
  - Retire of the head plus mispredict of a younger entry: both apply.
  - Simultaneous alloc + retire when full: the retire frees a slot first, so the alloc is accepted.
- Latency: clear_en, shift_en and err_out are registered single-cycle pulses, 1 cycle after the triggering input.
- Wrap-around: tags and pointers wrap modulo OBQ_SIZE. Tag OBQ_SIZE-1 yields index 0.
- Reset asserted mid-pulse: outputs drop immediately.

Test Plan:
- Reset: hold reset=0 → count_out=0, retire_ready=0, clear_en=0, shift_en=0, index=0, shift_index=0.
- Alloc tags 0,1,2,3; resolve tag 1 with mispred=1 → next cycle clear_en=1, index=2; count_out=2; entries for tags 2,3 gone.
- Alloc tags 0..2; resolve 0 correct; retire_en → next cycle shift_en=1, shift_index=1; count_out=2.
- retire_en with head unresolved → no shift, err_out pulse, count_out unchanged. Resolve of an untracked tag 9 → err_out pulse, no clear.
- Fill all 16 entries (tags 12..15,0..11); a 17th alloc → err_out. Retire tag 15 (resolved) → shift_index=0. Mispredict tag 15 → index=0.
- Same cycle: mispredict tag 4 + alloc tag 5 → alloc dropped, clear index=5. Retire head tag 3 + mispredict tag 3 → shift_en=1 and clear_en=1, both index values 4, count_out=0.
